// File: rtl/nvboard_btn_in.sv
// NVBoard push-button input block: 2-flop sync, per-input debounce, press pulses and a
// queued event stream. Define NVBOARD_BTN_RELEASE_EVT_EN to also queue release events.
module nvboard_btn_in #(
  parameter int unsigned N          = 5,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_state,
  output logic [N-1:0] btn_press,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [7:0]   evt_code,
  output logic         evt_overflow,
  input  logic         clr_ovf
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CntMax = CW'(DEB_CYCLES - 1);
  localparam logic [PW:0]   FillMax = (PW + 1)'(FIFO_DEPTH);

  logic [N-1:0]  sync1_q, sync_q, level_q, flip_q;
  logic [CW-1:0] cnt_q [N];

  logic [N-1:0]  pend_q, pend_d, ptype_q, ptype_d, grant, evt_set;
  logic          found, push, pop, ovf_set, full;
  logic [6:0]    push_idx;
  logic          push_type;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   fill_q;

  // Synchronizer and debounce; level_q is the accepted level, flip_q a one-cycle change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync_q  <= '0;
      level_q <= '0;
      flip_q  <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync_q  <= sync1_q;
      for (int unsigned i = 0; i < N; i++) begin
        flip_q[i] <= 1'b0;
        if (sync_q[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          level_q[i] <= ~level_q[i];
          cnt_q[i]   <= '0;
          flip_q[i]  <= 1'b1;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_state <= '0;
      btn_press <= '0;
    end else begin
      btn_state <= level_q;
      btn_press <= flip_q & level_q;
    end
  end

`ifdef NVBOARD_BTN_RELEASE_EVT_EN
  assign evt_set = flip_q;
`else
  assign evt_set = flip_q & level_q;
`endif

  assign full = (fill_q == FillMax);
  assign pop  = evt_valid & evt_ready;

  // Lowest-index pending input wins the single push slot.
  always_comb begin
    found     = 1'b0;
    grant     = '0;
    push_idx  = '0;
    push_type = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        push_idx  = 7'(i);
        push_type = ptype_q[i];
      end
    end
    push = found & (~full | pop);
  end

  // An entry pushed this cycle has left, so a new flip on it is not a collision.
  always_comb begin
    pend_d  = pend_q & ~(grant & {N{push}});
    ptype_d = ptype_q;
    ovf_set = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (evt_set[i]) begin
        if (pend_d[i]) begin
          pend_d[i] = 1'b0;
          ovf_set   = 1'b1;
        end else begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = level_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      ptype_q      <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      ptype_q <= ptype_d;
      if (ovf_set)      evt_overflow <= 1'b1;
      else if (clr_ovf) evt_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {push_type, push_idx};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + (PW + 1)'(1);
        2'b01:   fill_q <= fill_q - (PW + 1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign evt_valid = (fill_q != '0);
  assign evt_code  = evt_valid ? mem_q[rd_q] : 8'h00;

endmodule

// File: tb/tb_nvboard_btn_in.sv
// Self-checking bench for nvboard_btn_in: directed timing checks plus randomized toggles
// against an event-level reference model.
module tb_nvboard_btn_in;

  localparam int unsigned N   = 5;
  localparam int unsigned DEB = 4;
  localparam int unsigned FD  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_state, btn_press;
  logic         evt_valid, evt_ready, evt_overflow, clr_ovf;
  logic [7:0]   evt_code;

  int total = 0;
  int bad   = 0;
  int press_total = 0;
  logic [7:0] popped[$];
  logic [7:0] exp_q[$];

  nvboard_btn_in #(.N(N), .DEB_CYCLES(DEB), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_state    (btn_state),
    .btn_press    (btn_press),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow),
    .clr_ovf      (clr_ovf)
  );

  always #5 clk = ~clk;

  // Record every handshake and every press pulse as the DUT sees them at the edge.
  always @(posedge clk) begin
    if (evt_valid && evt_ready) popped.push_back(evt_code);
    press_total += $countones(btn_press);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_queue(input string tag);
    chk({tag, "_len"}, popped.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < popped.size(); k++)
      chk({tag, "_code"}, {24'h0, popped[k]}, {24'h0, exp_q[k]});
  endtask

  logic [N-1:0] lvl;
  logic         seen;
  int           idx, g, press_base, exp_press;

  initial begin
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b0; clr_ovf = 1'b0;
    tick(3);
    chk("rst_state", btn_state, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 8'h00);
    chk("rst_ovf", evt_overflow, 0);
    rst = 1'b0;

    // Debounce latency: change before edge 0, state and press at edge DEB+2.
    btn_raw[2] = 1'b1;
    tick(DEB + 2);
    chk("lat_state_early", btn_state, 0);
    tick(1);
    chk("lat_state", btn_state, 5'b00100);
    chk("lat_press", btn_press, 5'b00100);
    chk("lat_valid_early", evt_valid, 0);
    tick(1);
    chk("lat_press_width", btn_press, 0);
    chk("lat_valid", evt_valid, 1);
    chk("lat_code", evt_code, 8'h82);
    evt_ready = 1'b1;
    tick(1);
    chk("lat_pop_valid", evt_valid, 0);
    chk("lat_pop_code", evt_code, 8'h00);

    // Glitch of DEB-1 cycles never reaches the debounced level.
    btn_raw[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == DEB - 1) btn_raw[0] = 1'b0;
      tick(1);
      seen = seen | btn_state[0] | btn_press[0] | evt_valid;
    end
    chk("glitch", seen, 0);

    // Simultaneous flips drain in ascending index order.
    popped.delete();
    btn_raw = btn_raw | 5'b11010;
    tick(DEB + 3);
    chk("sim_state", btn_state, 5'b11110);
    chk("sim_press", btn_press, 5'b11010);
    tick(1);
    chk("sim_code0", evt_code, 8'h81);
    tick(1);
    chk("sim_code1", evt_code, 8'h83);
    tick(1);
    chk("sim_code2", evt_code, 8'h84);
    tick(1);
    chk("sim_empty", evt_valid, 0);

    btn_raw = '0;
    tick(16);
    chk("drop_state", btn_state, 0);
    popped.delete();

    // Backpressure: four entries fill the queue, the fifth press stays pending.
    evt_ready = 1'b0;
    btn_raw = '1;
    tick(14);
    chk("bp_valid", evt_valid, 1);
    chk("bp_head", evt_code, 8'h80);
    chk("bp_ovf0", evt_overflow, 0);
    btn_raw[4] = 1'b0;
    tick(10);
    btn_raw[4] = 1'b1;
    tick(10);
    chk("bp_state", btn_state, 5'b11111);
    chk("bp_ovf1", evt_overflow, 1);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    chk("bp_clr", evt_overflow, 0);
    evt_ready = 1'b1;
    tick(10);
    exp_q = '{8'h80, 8'h81, 8'h82, 8'h83};
`ifdef NVBOARD_BTN_RELEASE_EVT_EN
    exp_q.push_back(8'h84);
`endif
    chk_queue("bp_drain");

    // Release events.
    btn_raw = '0;
    tick(16);
    popped.delete();
    btn_raw[0] = 1'b1;
    tick(12);
    btn_raw[0] = 1'b0;
    tick(12);
    exp_q = '{8'h80};
`ifdef NVBOARD_BTN_RELEASE_EVT_EN
    exp_q.push_back(8'h00);
`endif
    chk_queue("rel");

    // Reset with two events queued and one debounce counter mid-count.
    evt_ready = 1'b0;
    btn_raw = 5'b00110;
    tick(12);
    chk("mid_valid", evt_valid, 1);
    btn_raw[0] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("mr_valid", evt_valid, 0);
    chk("mr_code", evt_code, 8'h00);
    chk("mr_state", btn_state, 0);
    rst = 1'b0;
    tick(DEB + 2);
    chk("mr_hold_early", btn_state, 0);
    tick(1);
    chk("mr_hold_state", btn_state, 5'b00111);
    chk("mr_hold_press", btn_press, 5'b00111);
    evt_ready = 1'b1;
    tick(10);
    popped.delete();

    // Randomized toggles and glitches against an event-level model.
    lvl = 5'b00111;
    exp_q.delete();
    exp_press = 0;
    press_base = press_total;
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 0) begin
        g = $urandom_range(1, DEB - 1);
        btn_raw[idx] = ~lvl[idx];
        tick(g);
        btn_raw[idx] = lvl[idx];
        tick(8);
      end else begin
        btn_raw[idx] = ~lvl[idx];
        tick(DEB + 8);
        lvl[idx] = ~lvl[idx];
        if (lvl[idx]) begin
          exp_q.push_back({1'b1, 7'(idx)});
          exp_press++;
        end
`ifdef NVBOARD_BTN_RELEASE_EVT_EN
        else exp_q.push_back({1'b0, 7'(idx)});
`endif
      end
      chk("rand_state", btn_state, lvl);
    end
    tick(4);
    chk_queue("rand");
    chk("rand_press_cnt", press_total - press_base, exp_press);
    chk("rand_ovf", evt_overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
